// File: rtl/dmem_access_unit.sv
// Data-memory access stage: aligns byte/half/word loads and stores
// into a word-wide synchronous RAM and right-justifies load data.
module dmem_access_unit #(
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ALIGN
  } state_t;

  state_t state, state_nx;

  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic [31:0] mem [2**ADDR_W];

  logic              illegal;
  logic              err_now;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic              fin;
  logic [3:0]        be;
  logic [31:0]       wlane;
  logic [31:0]       algn;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        k;
  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];
  assign widx = addr_q[ADDR_W+1:2];
  assign k    = addr_q[1:0];
  assign busy = (state != IDLE);

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      (size == 2'b11): illegal = 1'b1;
      (size == 2'b01): illegal = addr[0];
      (size == 2'b10): illegal = |addr[1:0];
      default:         illegal = 1'b0;
    endcase
  end

  assign err_now = (state == IDLE) && req && illegal;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && !illegal) begin
          accept   = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          wr_en    = 1'b1;
          fin      = 1'b1;
          state_nx = IDLE;
        end else begin
          rd_en    = 1'b1;
          state_nx = ALIGN;
        end
      end
      ALIGN: begin
        fin      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte enables and lane-replicated write data
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    unique case (1'b1)
      (size_q == 2'b00): begin
        be    = 4'b0001 << k;
        wlane = {4{wdata_q[7:0]}};
      end
      (size_q == 2'b01): begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata_q;
      end
    endcase
  end

  always_comb begin
    algn = word_q;
    unique case (1'b1)
      (size_q == 2'b00):
        algn = {24'b0, word_q[{k, 3'b000} +: 8]};
      (size_q == 2'b01):
        algn = {16'b0, word_q[{addr_q[1], 4'b0000} +: 16]};
      default:
        algn = word_q;
    endcase
  end

  // Reset outranks a pending write
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
    if (rd_en) word_q <= mem[widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      addr_err <= 1'b0;
      rdata    <= 32'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
    end else begin
      done     <= fin || err_now;
      addr_err <= err_now;
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata;
      end
      if (state == ALIGN) rdata <= algn;
    end
  end

endmodule
